// File: rtl/lpc_host_pkg.sv
// lpc_host_pkg: LPC nibble codes shared by the TPM-cycle host and its peripheral partner,
// plus SYNC nibble classification used by the host wait logic.
package lpc_host_pkg;

    localparam logic [3:0] LPC_START_TPM       = 4'b0101;
    localparam logic [3:0] LPC_START_ABORT     = 4'b1111;
    localparam logic [3:0] LPC_CYC_WR          = 4'b0010;
    localparam logic [3:0] LPC_CYC_RD          = 4'b0000;
    localparam logic [3:0] LPC_SYNC_READY      = 4'b0000;
    localparam logic [3:0] LPC_SYNC_SHORT_WAIT = 4'b0101;
    localparam logic [3:0] LPC_SYNC_LONG_WAIT  = 4'b0110;
    localparam logic [3:0] LPC_SYNC_ERROR      = 4'b1010;
    localparam logic [3:0] LPC_TAR             = 4'b1111;

    typedef enum logic [1:0] {
        SYNC_KIND_READY,
        SYNC_KIND_ERROR,
        SYNC_KIND_LONG,
        SYNC_KIND_SHORT
    } sync_kind_e;

    // Short waits and unrecognised nibbles share the short-wait counter.
    function automatic sync_kind_e classify_sync(input logic [3:0] nib);
        case (nib)
            LPC_SYNC_READY:     return SYNC_KIND_READY;
            LPC_SYNC_ERROR:     return SYNC_KIND_ERROR;
            LPC_SYNC_LONG_WAIT: return SYNC_KIND_LONG;
            default:            return SYNC_KIND_SHORT;
        endcase
    endfunction

endpackage

// File: rtl/lpc_host.sv
// lpc_host: LPC initiator turning a single-request command port into a complete TPM read or
// write cycle, with SYNC wait handling, timeout and abort. All outputs are registered.
//
// state   | meaning
// IDLE    | bus idle, waiting for req_i
// START   | LFRAME# low, TPM start code on LAD
// CYCTYPE | cycle type / direction nibble
// ADDR    | 16-bit address, most significant nibble first
// WDATA   | write data, least significant nibble first
// TAR_H   | drive LAD high before turnaround
// TAR_Z   | release LAD to the peripheral
// SYNC    | wait for ready or error sync nibble
// RDATA   | capture read data, least significant nibble first
// TAR_P   | peripheral turns the bus back
// ABORT   | LFRAME# low with LAD high for four cycles
// DONE    | completion pulse; next request may be accepted
module lpc_host
    import lpc_host_pkg::*;
#(
    parameter int SYNC_TIMEOUT  = 8,
    parameter int LONG_WAIT_MAX = 1024
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [15:0] addr_i,
    input  logic [7:0]  wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [7:0]  rdata_o,
    output logic        lframe_o,
    output logic [3:0]  lad_o,
    output logic        lad_oe_o,
    input  logic [3:0]  lad_i
);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_START   = 4'd1;
    localparam logic [3:0] ST_CYCTYPE = 4'd2;
    localparam logic [3:0] ST_ADDR    = 4'd3;
    localparam logic [3:0] ST_WDATA   = 4'd4;
    localparam logic [3:0] ST_TAR_H   = 4'd5;
    localparam logic [3:0] ST_TAR_Z   = 4'd6;
    localparam logic [3:0] ST_SYNC    = 4'd7;
    localparam logic [3:0] ST_RDATA   = 4'd8;
    localparam logic [3:0] ST_TAR_P   = 4'd9;
    localparam logic [3:0] ST_ABORT   = 4'd10;
    localparam logic [3:0] ST_DONE    = 4'd11;

    localparam int SW = $clog2(SYNC_TIMEOUT + 1);
    localparam int LW = $clog2(LONG_WAIT_MAX + 1);
    localparam logic [SW-1:0] SHORT_LIM = SW'(SYNC_TIMEOUT);
    localparam logic [LW-1:0] LONG_LIM  = LW'(LONG_WAIT_MAX);

    logic [3:0]    state_q, state_d;
    logic [1:0]    nib_q, nib_d;
    logic [SW-1:0] short_q, short_d;
    logic [LW-1:0] long_q, long_d;
    logic          we_q, we_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    shift_q, shift_d;
    logic          serr_q, serr_d;
    logic          aborted_q, aborted_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          lframe_q, lframe_d;
    logic [3:0]    lad_q, lad_d;
    logic          lad_oe_q, lad_oe_d;

    sync_kind_e    sync_kind;

    assign sync_kind = classify_sync(lad_i);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            nib_q     <= '0;
            short_q   <= '0;
            long_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            shift_q   <= '0;
            serr_q    <= 1'b0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 8'h00;
            lframe_q  <= 1'b1;
            lad_q     <= 4'hF;
            lad_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            nib_q     <= nib_d;
            short_q   <= short_d;
            long_q    <= long_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            shift_q   <= shift_d;
            serr_q    <= serr_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            lframe_q  <= lframe_d;
            lad_q     <= lad_d;
            lad_oe_q  <= lad_oe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        nib_d     = nib_q;
        short_d   = short_q;
        long_d    = long_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        shift_d   = shift_q;
        serr_d    = serr_q;
        aborted_d = aborted_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (req_i) begin
                    state_d   = ST_START;
                    we_d      = we_i;
                    addr_d    = addr_i;
                    wdata_d   = wdata_i;
                    serr_d    = 1'b0;
                    aborted_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: state_d = ST_CYCTYPE;
            ST_CYCTYPE: begin
                state_d = ST_ADDR;
                nib_d   = 2'd3;
            end
            ST_ADDR: begin
                if (nib_q != 2'd0) begin
                    nib_d = nib_q - 2'd1;
                end else if (we_q) begin
                    state_d = ST_WDATA;
                    nib_d   = 2'd1;
                end else begin
                    state_d = ST_TAR_H;
                end
            end
            ST_WDATA: begin
                if (nib_q != 2'd0) nib_d = nib_q - 2'd1;
                else               state_d = ST_TAR_H;
            end
            ST_TAR_H: state_d = ST_TAR_Z;
            ST_TAR_Z: begin
                state_d = ST_SYNC;
                short_d = '0;
                long_d  = '0;
            end
            ST_SYNC: begin
                if (sync_kind == SYNC_KIND_READY || sync_kind == SYNC_KIND_ERROR) begin
                    if (sync_kind == SYNC_KIND_ERROR) serr_d = 1'b1;
                    state_d = we_q ? ST_TAR_P : ST_RDATA;
                    nib_d   = 2'd1;
                end else if (sync_kind == SYNC_KIND_LONG) begin
                    short_d = '0;
                    if (long_q != LONG_LIM) long_d = long_q + LW'(1);
                    if (long_d == LONG_LIM) begin
                        state_d   = ST_ABORT;
                        nib_d     = 2'd3;
                        aborted_d = 1'b1;
                    end
                end else begin
                    long_d = '0;
                    if (short_q != SHORT_LIM) short_d = short_q + SW'(1);
                    if (short_d == SHORT_LIM) begin
                        state_d   = ST_ABORT;
                        nib_d     = 2'd3;
                        aborted_d = 1'b1;
                    end
                end
            end
            ST_RDATA: begin
                // Right shift puts the first (low) nibble in [3:0] after two captures.
                shift_d = {lad_i, shift_q[7:4]};
                if (nib_q != 2'd0) begin
                    nib_d = nib_q - 2'd1;
                end else begin
                    state_d = ST_TAR_P;
                    nib_d   = 2'd1;
                end
            end
            ST_TAR_P, ST_ABORT: begin
                if (nib_q != 2'd0) nib_d = nib_q - 2'd1;
                else               state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land in the flops with the state.
    always_comb begin
        busy_d   = 1'b1;
        done_d   = 1'b0;
        err_d    = err_q;
        rdata_d  = rdata_q;
        lframe_d = 1'b1;
        lad_d    = LPC_TAR;
        lad_oe_d = 1'b0;
        case (state_d)
            ST_IDLE: busy_d = 1'b0;
            ST_START: begin
                lframe_d = 1'b0;
                lad_d    = LPC_START_TPM;
                lad_oe_d = 1'b1;
                err_d    = 1'b0;
            end
            ST_CYCTYPE: begin
                lad_d    = we_q ? LPC_CYC_WR : LPC_CYC_RD;
                lad_oe_d = 1'b1;
            end
            ST_ADDR: begin
                lad_oe_d = 1'b1;
                case (nib_d)
                    2'd3:    lad_d = addr_q[15:12];
                    2'd2:    lad_d = addr_q[11:8];
                    2'd1:    lad_d = addr_q[7:4];
                    default: lad_d = addr_q[3:0];
                endcase
            end
            ST_WDATA: begin
                lad_oe_d = 1'b1;
                lad_d    = nib_d[0] ? wdata_q[3:0] : wdata_q[7:4];
            end
            ST_TAR_H: lad_oe_d = 1'b1;
            ST_ABORT: begin
                lframe_d = 1'b0;
                lad_d    = LPC_START_ABORT;
                lad_oe_d = 1'b1;
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                err_d   = serr_q | aborted_q;
                rdata_d = aborted_q ? 8'hFF : (we_q ? rdata_q : shift_q);
            end
            default: ;
        endcase
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;
    assign lframe_o = lframe_q;
    assign lad_o    = lad_q;
    assign lad_oe_o = lad_oe_q;

endmodule

// File: tb/tb_lpc_host.sv
// tb_lpc_host: directed bench for lpc_host; per-cycle expected bus/status values are queued
// when a request is issued and popped as the DUT runs, with a peripheral stimulus queue alongside.
module tb_lpc_host;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic [3:0]  lad_in = 4'hF;

    logic        a_busy, a_done, a_err, a_lframe, a_oe;
    logic [7:0]  a_rdata;
    logic [3:0]  a_lad;
    logic        b_busy, b_done, b_err, b_lframe, b_oe;
    logic [7:0]  b_rdata;
    logic [3:0]  b_lad;

    always #5 clk = ~clk;

    lpc_host dut (
        .clk_i(clk), .rstn_i(rstn), .req_i(req_a), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .busy_o(a_busy), .done_o(a_done), .err_o(a_err), .rdata_o(a_rdata),
        .lframe_o(a_lframe), .lad_o(a_lad), .lad_oe_o(a_oe), .lad_i(lad_in)
    );

    lpc_host #(.LONG_WAIT_MAX(50)) dut50 (
        .clk_i(clk), .rstn_i(rstn), .req_i(req_b), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .busy_o(b_busy), .done_o(b_done), .err_o(b_err), .rdata_o(b_rdata),
        .lframe_o(b_lframe), .lad_o(b_lad), .lad_oe_o(b_oe), .lad_i(lad_in)
    );

    typedef struct packed {
        logic       done;
        logic       busy;
        logic       err;
        logic       lframe;
        logic       oe;
        logic [3:0] lad;
        logic [7:0] rdata;
    } obs_t;

    int         checks = 0;
    int         errors = 0;
    obs_t       exp_q[$];
    logic [3:0] drv_q[$];
    logic [3:0] sync_list[$];
    logic [7:0] exp_rdata[2];
    logic       exp_err[2];
    bit         use50 = 1'b0;

    function automatic obs_t get_obs();
        obs_t o;
        if (use50) o = '{b_done, b_busy, b_err, b_lframe, b_oe, b_lad, b_rdata};
        else       o = '{a_done, a_busy, a_err, a_lframe, a_oe, a_lad, a_rdata};
        if (!o.oe) o.lad = 4'h0;
        return o;
    endfunction

    function automatic obs_t idle_exp(input int idx);
        obs_t e;
        e = '{1'b0, 1'b0, exp_err[idx], 1'b1, 1'b0, 4'h0, exp_rdata[idx]};
        return e;
    endfunction

    task automatic check(input string tag, input int cyc, input obs_t got, input obs_t expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed done/busy/err/lframe/oe/lad/rdata=%b/%b/%b/%b/%b/%h/%h required %b/%b/%b/%b/%b/%h/%h",
                   tag, cyc, got.done, got.busy, got.err, got.lframe, got.oe, got.lad, got.rdata,
                   expv.done, expv.busy, expv.err, expv.lframe, expv.oe, expv.lad, expv.rdata);
        end
    endtask

    task automatic push_cyc(input logic lf, input logic oe, input logic [3:0] lad,
                            input logic [3:0] drv, input int idx);
        obs_t e;
        e = '{1'b0, 1'b1, 1'b0, lf, oe, (oe ? lad : 4'h0), exp_rdata[idx]};
        exp_q.push_back(e);
        drv_q.push_back(drv);
    endtask

    // Drive a request and queue the cycle-by-cycle expectations, using sync_list as the
    // peripheral's SYNC nibbles (LAD pulled high once the list runs out).
    task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] rd, input bit b50);
        int lmax;
        int sh;
        int lg;
        int i;
        int idx;
        bit ready;
        bit abrt;
        bit serr;
        logic [3:0] nib;
        obs_t e;
        lmax = b50 ? 50 : 1024;
        idx  = b50 ? 1 : 0;
        sh = 0; lg = 0; i = 0; ready = 0; abrt = 0; serr = 0;
        use50 = b50;
        we = wr; addr = a; wdata = wd;
        if (b50) req_b = 1'b1; else req_a = 1'b1;
        push_cyc(1'b0, 1'b1, 4'h5, 4'hF, idx);
        push_cyc(1'b1, 1'b1, (wr ? 4'h2 : 4'h0), 4'hF, idx);
        for (int k = 3; k >= 0; k--) push_cyc(1'b1, 1'b1, a[k*4 +: 4], 4'hF, idx);
        if (wr) begin
            push_cyc(1'b1, 1'b1, wd[3:0], 4'hF, idx);
            push_cyc(1'b1, 1'b1, wd[7:4], 4'hF, idx);
        end
        push_cyc(1'b1, 1'b1, 4'hF, 4'hF, idx);
        push_cyc(1'b1, 1'b0, 4'h0, 4'hF, idx);
        while (!ready && !abrt && i < 4000) begin
            nib = (i < sync_list.size()) ? sync_list[i] : 4'hF;
            push_cyc(1'b1, 1'b0, 4'h0, nib, idx);
            if (nib == 4'h0 || nib == 4'hA) begin
                ready = 1;
                serr  = (nib == 4'hA);
            end else if (nib == 4'h6) begin
                lg++;
                sh = 0;
                if (lg >= lmax) abrt = 1;
            end else begin
                sh++;
                lg = 0;
                if (sh >= 8) abrt = 1;
            end
            i++;
        end
        if (abrt) begin
            repeat (4) push_cyc(1'b0, 1'b1, 4'hF, 4'hF, idx);
        end else begin
            if (!wr) begin
                push_cyc(1'b1, 1'b0, 4'h0, rd[3:0], idx);
                push_cyc(1'b1, 1'b0, 4'h0, rd[7:4], idx);
            end
            push_cyc(1'b1, 1'b0, 4'h0, 4'hF, idx);
            push_cyc(1'b1, 1'b0, 4'h0, 4'hF, idx);
        end
        e = '{1'b1, 1'b0, (abrt | serr), 1'b1, 1'b0, 4'h0,
              (abrt ? 8'hFF : (wr ? exp_rdata[idx] : rd))};
        exp_q.push_back(e);
        drv_q.push_back(4'hF);
        exp_rdata[idx] = e.rdata;
        exp_err[idx]   = e.err;
    endtask

    // Starts at the negedge where the request is presented; ends at the negedge of the last
    // checked cycle (the DONE cycle for a full run).
    task automatic run_xfer(input string tag, input int maxc);
        obs_t e;
        int n;
        n = 0;
        @(posedge clk);
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
        we = ~we; addr = ~addr; wdata = ~wdata;
        while (exp_q.size() > 0 && n < maxc) begin
            e = exp_q.pop_front();
            lad_in = drv_q.pop_front();
            n++;
            check(tag, n, get_obs(), e);
            if (exp_q.size() > 0 && n < maxc) @(negedge clk);
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check(tag, 0, get_obs(), idle_exp(use50 ? 1 : 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, observed time %0t required < 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_rdata = '{8'h00, 8'h00};
        exp_err   = '{1'b0, 1'b0};
        @(negedge clk);
        use50 = 1'b0; check("reset_a", 0, get_obs(), idle_exp(0));
        use50 = 1'b1; check("reset_b", 0, get_obs(), idle_exp(1));
        use50 = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        idle_check("idle0");

        sync_list = {4'h0};
        issue(1'b1, 16'h0024, 8'hA5, 8'h00, 1'b0);
        run_xfer("wr_0024", 9999);

        sync_list = {4'h5, 4'h5, 4'h5, 4'h0};
        issue(1'b0, 16'h0F00, 8'h00, 8'h3C, 1'b0);
        run_xfer("rd_0f00_b2b", 9999);

        sync_list.delete();
        issue(1'b0, 16'h1234, 8'h00, 8'h00, 1'b0);
        run_xfer("no_resp", 9999);
        idle_check("idle_abort");

        sync_list.delete();
        repeat (100) sync_list.push_back(4'h6);
        sync_list.push_back(4'h0);
        issue(1'b1, 16'h00AA, 8'h5A, 8'h00, 1'b0);
        run_xfer("long100", 9999);
        idle_check("idle_long100");

        issue(1'b1, 16'h00AA, 8'h5A, 8'h00, 1'b1);
        run_xfer("long100_max50", 9999);
        idle_check("idle_max50");

        sync_list.delete();
        repeat (49) sync_list.push_back(4'h6);
        sync_list.push_back(4'h0);
        issue(1'b0, 16'h8001, 8'h00, 8'h42, 1'b1);
        run_xfer("long49_max50", 9999);
        idle_check("idle_long49");

        sync_list = {4'h5, 4'hA};
        issue(1'b0, 16'h0C0C, 8'h00, 8'h11, 1'b0);
        run_xfer("err_sync", 9999);
        idle_check("idle_err");

        sync_list = {4'h5, 4'h3, 4'h5, 4'h9, 4'h5, 4'h5, 4'hC, 4'h0};
        issue(1'b0, 16'hBEEF, 8'h00, 8'h96, 1'b0);
        run_xfer("short7", 9999);

        sync_list = {4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h6, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h0};
        issue(1'b1, 16'h4455, 8'hC3, 8'h00, 1'b0);
        run_xfer("short_split_b2b", 9999);
        idle_check("idle_split");

        sync_list = {4'h0};
        issue(1'b1, 16'h0300, 8'h77, 8'h00, 1'b0);
        run_xfer("rst_pre", 4);
        #2 rstn = 1'b0;
        #1;
        exp_q.delete();
        drv_q.delete();
        exp_rdata = '{8'h00, 8'h00};
        exp_err   = '{1'b0, 1'b0};
        use50 = 1'b0; check("rst_async_a", 0, get_obs(), idle_exp(0));
        use50 = 1'b1; check("rst_async_b", 0, get_obs(), idle_exp(1));
        use50 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            check("rst_no_done", c, get_obs(), idle_exp(0));
        end

        sync_list = {4'h0};
        issue(1'b1, 16'h0024, 8'hA5, 8'h00, 1'b0);
        run_xfer("wr_after_rst", 9999);
        idle_check("idle_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
